// File: rtl/pe_dispatch_scheduler.sv
// pe_dispatch_scheduler: frame-level scheduler for a bank of PE units.
// Hands candidate indices q = 0..NUM_Q-1 to idle PEs (one start per cycle),
// captures each PE's d_q on its valid strobe, keeps a running signed minimum
// (ties go to the lower q), and pulses done with the winner.
// Optional watchdog: define PE_SCHED_TIMEOUT_EN to abort a stalled frame
// after TIMEOUT_CYCLES quiet cycles and pulse err together with done.
module pe_dispatch_scheduler #(
    parameter int NUM_Q          = 8,
    parameter int NUM_PE         = 4,
    parameter int ACC_WIDTH      = 48,
    parameter int QW             = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    output logic                          busy,
    output logic [NUM_PE-1:0]             pe_start,
    output logic [NUM_PE*QW-1:0]          pe_q_idx,
    input  logic [NUM_PE-1:0]             pe_valid,
    input  logic [NUM_PE*ACC_WIDTH-1:0]   pe_dq_flat,
    output logic [QW-1:0]                 best_q,
    output logic signed [ACC_WIDTH-1:0]   best_dq,
    output logic                          done,
    output logic                          err
);

    // Counters must reach NUM_Q itself, which needs one bit more than a q index.
    localparam int CW  = QW + 1;
    localparam int PIW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [CW-1:0] NUM_Q_C = CW'(NUM_Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                        r_state;
    logic                          r_busy;
    logic                          r_done;
    logic [NUM_PE-1:0]             r_pe_start;
    logic [NUM_PE*QW-1:0]          r_pe_q_idx;
    logic [NUM_PE-1:0]             r_busy_pe;
    logic [NUM_PE-1:0]             r_pend;
    logic [CW-1:0]                 r_next_q;
    logic [CW-1:0]                 r_done_cnt;
    logic                          r_best_valid;
    logic [QW-1:0]                 r_best_q;
    logic signed [ACC_WIDTH-1:0]   r_best_dq;
    logic [QW-1:0]                 r_slot_q  [NUM_PE];
    logic signed [ACC_WIDTH-1:0]   r_slot_dq [NUM_PE];

    logic                          w_run;
    logic [NUM_PE-1:0]             w_free;
    logic [NUM_PE-1:0]             w_cap;
    logic                          w_disp_found;
    logic [NUM_PE-1:0]             w_disp_oh;
    logic                          w_disp_go;
    logic [QW-1:0]                 w_disp_q;
    logic                          w_cmp_found;
    logic [NUM_PE-1:0]             w_cmp_oh;
    logic [PIW-1:0]                w_cmp_pe;
    logic                          w_cmp_go;
    logic [QW-1:0]                 w_cmp_q;
    logic signed [ACC_WIDTH-1:0]   w_cmp_dq;
    logic                          w_better;
    logic                          w_timeout;

    // A slot beats the current best when there is none yet, when its d_q is
    // strictly smaller, or when d_q ties and its q is lower.
    function automatic logic beats(
        input logic signed [ACC_WIDTH-1:0] dq,
        input logic [QW-1:0]               q,
        input logic signed [ACC_WIDTH-1:0] bdq,
        input logic [QW-1:0]               bq,
        input logic                        bvalid
    );
        return !bvalid || (dq < bdq) || ((dq == bdq) && (q < bq));
    endfunction

    assign w_run  = (r_state == S_RUN);
    // A PE is reusable only once its previous result has been compared.
    assign w_free = ~r_busy_pe & ~r_pend;
    // Strobes from PEs we did not start (or outside RUN) are dropped here.
    assign w_cap  = w_run ? (pe_valid & r_busy_pe) : '0;

    // Priority pick: lowest free PE for dispatch, lowest pending slot for compare
    always_comb begin
        w_disp_found = 1'b0;
        w_disp_oh    = '0;
        w_cmp_found  = 1'b0;
        w_cmp_oh     = '0;
        w_cmp_pe     = '0;
        for (int p = NUM_PE - 1; p >= 0; p--) begin
            if (w_free[p]) begin
                w_disp_found = 1'b1;
                w_disp_oh    = '0;
                w_disp_oh[p] = 1'b1;
            end
            if (r_pend[p]) begin
                w_cmp_found = 1'b1;
                w_cmp_oh    = '0;
                w_cmp_oh[p] = 1'b1;
                w_cmp_pe    = PIW'(p);
            end
        end
    end

    // The start pulse is registered, so the first dispatch is decided in the
    // IDLE cycle that accepts frame_start and appears in the first RUN cycle.
    assign w_disp_go = w_disp_found && !w_timeout &&
                       ((w_run && (r_next_q < NUM_Q_C)) ||
                        ((r_state == S_IDLE) && frame_start));
    assign w_disp_q  = w_run ? r_next_q[QW-1:0] : '0;

    assign w_cmp_go  = w_run && w_cmp_found;
    assign w_cmp_q   = r_slot_q[w_cmp_pe];
    assign w_cmp_dq  = r_slot_dq[w_cmp_pe];
    assign w_better  = beats(w_cmp_dq, w_cmp_q, r_best_dq, r_best_q, r_best_valid);

    // Result slots hold captured d_q and its q; data only, so no reset
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PE; p++) begin
            if (w_cap[p]) begin
                r_slot_dq[p] <= pe_dq_flat[p*ACC_WIDTH +: ACC_WIDTH];
                r_slot_q[p]  <= r_pe_q_idx[p*QW +: QW];
            end
        end
    end

    // Frame FSM with dispatch, capture bookkeeping and running-minimum compare
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pe_start   <= '0;
            r_pe_q_idx   <= '0;
            r_busy_pe    <= '0;
            r_pend       <= '0;
            r_next_q     <= '0;
            r_done_cnt   <= '0;
            r_best_valid <= 1'b0;
            r_best_q     <= '0;
            r_best_dq    <= '0;
        end else begin
            r_pe_start <= w_disp_go ? w_disp_oh : '0;
            r_done     <= 1'b0;
            r_busy_pe  <= (r_busy_pe | (w_disp_go ? w_disp_oh : '0)) & ~w_cap;
            r_pend     <= (r_pend & ~(w_cmp_go ? w_cmp_oh : '0)) | w_cap;
            for (int p = 0; p < NUM_PE; p++) begin
                if (w_disp_go && w_disp_oh[p]) begin
                    r_pe_q_idx[p*QW +: QW] <= w_disp_q;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_next_q     <= w_disp_go ? CW'(1) : '0;
                        r_done_cnt   <= '0;
                        r_best_valid <= 1'b0;
                        r_best_q     <= '0;
                        r_best_dq    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_disp_go) begin
                        r_next_q <= r_next_q + CW'(1);
                    end
                    if (w_cmp_go) begin
                        r_done_cnt <= r_done_cnt + CW'(1);
                        if (w_better) begin
                            r_best_valid <= 1'b1;
                            r_best_q     <= w_cmp_q;
                            r_best_dq    <= w_cmp_dq;
                        end
                    end
                    if (w_timeout) begin
                        // Abandon outstanding work; best so far is kept.
                        r_state   <= S_FINISH;
                        r_done    <= 1'b1;
                        r_busy_pe <= '0;
                        r_pend    <= '0;
                    end else if ((r_done_cnt == NUM_Q_C) && (r_pend == '0)) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wd;
    logic           r_err;

    // Fires on the TIMEOUT_CYCLES-th consecutive quiet cycle with work outstanding.
    assign w_timeout = w_run && (pe_valid == '0) && (r_busy_pe != '0) &&
                       (r_wd == WDW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts stalled RUN cycles; err is raised in step with done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state == S_IDLE) && frame_start) begin
                r_wd <= '0;
            end else if (w_run) begin
                if (pe_valid != '0) begin
                    r_wd <= '0;
                end else if (r_busy_pe != '0) begin
                    r_wd <= r_wd + 1'b1;
                end
            end
        end
    end

    assign err = r_err;
`else
    // TIMEOUT_CYCLES has no role without the watchdog.
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    assign busy     = r_busy;
    assign pe_start = r_pe_start;
    assign pe_q_idx = r_pe_q_idx;
    assign best_q   = r_best_q;
    assign best_dq  = r_best_dq;
    assign done     = r_done;

endmodule
